// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage front end.
//  - ALU operation encodings carried on alucontrol[2:0]
//  - fwd_sel_t: operand source select used by the forwarding muxes
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bus bundle between decode / MEM / WB / hazard unit and the ID/EX operand stage.
//  master : the surrounding pipeline (drives D-stage, forward sources, stall/flush)
//  slave  : ex_operand_stage (drives E-stage operands/control and loaduseD)
interface ex_operand_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
);

  // pipeline control
  logic               stall;
  logic               flush;
  // decode-stage operands and control
  logic [WIDTH-1:0]   rd1D;
  logic [WIDTH-1:0]   rd2D;
  logic [WIDTH-1:0]   signimmD;
  logic [REGBITS-1:0] rsD;
  logic [REGBITS-1:0] rtD;
  logic [REGBITS-1:0] rdD;
  logic [2:0]         alucontrolD;
  logic               alusrcD;
  logic               regdstD;
  logic               regwriteD;
  logic               memwriteD;
  logic               memtoregD;
  // forward sources
  logic [WIDTH-1:0]   aluoutM;
  logic [REGBITS-1:0] writeregM;
  logic               regwriteM;
  logic [WIDTH-1:0]   resultW;
  logic [REGBITS-1:0] writeregW;
  logic               regwriteW;
  // execute-stage outputs
  logic [WIDTH-1:0]   srcaE;
  logic [WIDTH-1:0]   srcbE;
  logic [2:0]         alucontrolE;
  logic [WIDTH-1:0]   writedataE;
  logic [REGBITS-1:0] writeregE;
  logic               regwriteE;
  logic               memwriteE;
  logic               memtoregE;
  logic               validE;
  logic               loaduseD;

  modport master (
    output stall, flush,
    output rd1D, rd2D, signimmD, rsD, rtD, rdD,
    output alucontrolD, alusrcD, regdstD, regwriteD, memwriteD, memtoregD,
    output aluoutM, writeregM, regwriteM, resultW, writeregW, regwriteW,
    input  srcaE, srcbE, alucontrolE, writedataE, writeregE,
    input  regwriteE, memwriteE, memtoregE, validE, loaduseD
  );

  modport slave (
    input  stall, flush,
    input  rd1D, rd2D, signimmD, rsD, rtD, rdD,
    input  alucontrolD, alusrcD, regdstD, regwriteD, memwriteD, memtoregD,
    input  aluoutM, writeregM, regwriteM, resultW, writeregW, regwriteW,
    output srcaE, srcbE, alucontrolE, writedataE, writeregE,
    output regwriteE, memwriteE, memtoregE, validE, loaduseD
  );

endinterface

// File: rtl/mux2.sv
// 2:1 multiplexer.
//  d0, d1 : data inputs (WIDTH)
//  s      : select, 1 picks d1
//  y      : output (WIDTH)
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux3.sv
// 3:1 multiplexer used for operand forwarding.
//  d0, d1, d2 : data inputs (WIDTH)
//  s          : select 00->d0, 01->d1, 10->d2 (11 falls back to d0)
//  y          : output (WIDTH)
module mux3 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (s)
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand forwarding for the execute stage.
// Latches decoded operands/control, resolves RAW hazards by forwarding from
// MEM (priority) and WB, selects the immediate for srcb, and reports
// load-use hazards against the instruction currently in decode.
//  clk, reset : clock and synchronous active-high reset
//  bus        : ex_operand_stage_if.slave
//               in : stall, flush, D-stage operands/control, M/W forward sources
//               out: srcaE, srcbE, alucontrolE, writedataE, writeregE,
//                    regwriteE, memwriteE, memtoregE, validE, loaduseD
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  ex_operand_stage_if.slave   bus
);

  logic [WIDTH-1:0]   rd1_p1;
  logic [WIDTH-1:0]   rd2_p1;
  logic [WIDTH-1:0]   imm_p1;
  logic [REGBITS-1:0] rs_p1;
  logic [REGBITS-1:0] rt_p1;
  logic [REGBITS-1:0] rd_p1;
  logic [2:0]         aluctl_p1;
  logic               alusrc_p1;
  logic               regdst_p1;
  logic               regwrite_p1;
  logic               memwrite_p1;
  logic               memtoreg_p1;
  logic               vld_p1;

  fwd_sel_t           fwd_a;
  fwd_sel_t           fwd_b;
  logic [WIDTH-1:0]   writedata;

  // ---- D -> E stage boundary ----
  // A flushed or reset stage holds an all-zero bubble, so rs/rt read $0 and
  // forwarding can never fire on it.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      aluctl_p1   <= ALU_AND;
      alusrc_p1   <= 1'b0;
      regdst_p1   <= 1'b0;
      regwrite_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      vld_p1      <= 1'b0;
    end else if (!bus.stall) begin
      rd1_p1      <= bus.rd1D;
      rd2_p1      <= bus.rd2D;
      imm_p1      <= bus.signimmD;
      rs_p1       <= bus.rsD;
      rt_p1       <= bus.rtD;
      rd_p1       <= bus.rdD;
      aluctl_p1   <= bus.alucontrolD;
      alusrc_p1   <= bus.alusrcD;
      regdst_p1   <= bus.regdstD;
      regwrite_p1 <= bus.regwriteD;
      memwrite_p1 <= bus.memwriteD;
      memtoreg_p1 <= bus.memtoregD;
      vld_p1      <= 1'b1;
    end
  end

  // Forward selects: MEM is the younger producer so it wins over WB; $0 is
  // hard-wired zero and is never forwarded.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (bus.regwriteM && (bus.writeregM != '0) && (bus.writeregM == rs_p1))
      fwd_a = FWD_MEM;
    else if (bus.regwriteW && (bus.writeregW != '0) && (bus.writeregW == rs_p1))
      fwd_a = FWD_WB;
    if (bus.regwriteM && (bus.writeregM != '0) && (bus.writeregM == rt_p1))
      fwd_b = FWD_MEM;
    else if (bus.regwriteW && (bus.writeregW != '0) && (bus.writeregW == rt_p1))
      fwd_b = FWD_WB;
  end

  mux3 #(.WIDTH(WIDTH)) u_fwd_a (
    .d0 (rd1_p1),
    .d1 (bus.resultW),
    .d2 (bus.aluoutM),
    .s  (fwd_a),
    .y  (bus.srcaE)
  );

  mux3 #(.WIDTH(WIDTH)) u_fwd_b (
    .d0 (rd2_p1),
    .d1 (bus.resultW),
    .d2 (bus.aluoutM),
    .s  (fwd_b),
    .y  (writedata)
  );

  mux2 #(.WIDTH(WIDTH)) u_srcb (
    .d0 (writedata),
    .d1 (imm_p1),
    .s  (alusrc_p1),
    .y  (bus.srcbE)
  );

  assign bus.writedataE  = writedata;
  assign bus.writeregE   = regdst_p1 ? rd_p1 : rt_p1;
  assign bus.alucontrolE = aluctl_p1;
  assign bus.regwriteE   = regwrite_p1;
  assign bus.memwriteE   = memwrite_p1;
  assign bus.memtoregE   = memtoreg_p1;
  assign bus.validE      = vld_p1;

  // Load in E whose destination (rt) is a source of the decode instruction.
  // Deliberately not gated by stall: the hazard unit needs it while stalling.
  assign bus.loaduseD = vld_p1 && memtoreg_p1 &&
                        ((rt_p1 == bus.rsD) || (rt_p1 == bus.rtD));

endmodule
